// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side burst streamer.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    SETTLE = 2'd2
  } rd_state_e;

  localparam int SETTLE_CYC = 2;
  localparam int SETTLE_W   = $clog2(SETTLE_CYC);

  // Default skid entry; the top re-declares it at its own DSIZE.
  localparam int SKID_DSIZE = 8;
  typedef struct packed {
    logic                  last;
    logic [SKID_DSIZE-1:0] data;
  } skid_entry_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus outgoing valid/ready stream of the burst reader.
interface fifo_burst_reader_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 10
);
  logic             f_r_en;
  logic             f_r_ok;
  logic [DSIZE-1:0] f_rdata;
  logic [ASIZE-1:0] f_ruse;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;

  modport master (
    output f_r_en, m_valid, m_data, m_last,
    input  f_r_ok, f_rdata, f_ruse, m_ready
  );

  modport slave (
    input  f_r_en, m_valid, m_data, m_last,
    output f_r_ok, f_rdata, f_ruse, m_ready
  );
endinterface

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer; head entry drives the output directly.
module stream_skid2
  import fifo_stream_pkg::*;
#(
  parameter type entry_t = skid_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  entry_t     in_entry,
  output logic       out_valid,
  input  logic       out_ready,
  output entry_t     out_entry,
  output logic [1:0] cnt
);
  entry_t     head_r, tail_r, head_nxt_s, tail_nxt_s;
  logic [1:0] cnt_r, cnt_nxt_s;
  logic       pop_s;

  assign out_valid = (cnt_r != 2'd0);
  assign out_entry = head_r;
  assign cnt       = cnt_r;

  // Next contents: a simultaneous push and pop keeps the count unchanged.
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    cnt_nxt_s  = cnt_r;
    pop_s      = out_valid & out_ready;
    case ({in_valid, pop_s})
      2'b10: begin
        if (cnt_r == 2'd0) begin
          head_nxt_s = in_entry;
          cnt_nxt_s  = 2'd1;
        end else if (cnt_r == 2'd1) begin
          tail_nxt_s = in_entry;
          cnt_nxt_s  = 2'd2;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      2'b01: begin
        head_nxt_s = tail_r;
        cnt_nxt_s  = cnt_r - 2'd1;
      end
      2'b11: begin
        if (cnt_r == 2'd2) begin
          head_nxt_s = tail_r;
          tail_nxt_s = in_entry;
        end else begin
          head_nxt_s = in_entry;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Storage registers; reset discards any held words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= '0;
      tail_r <= '0;
      cnt_r  <= 2'd0;
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the async FIFO read port and re-emits words as BURST_LEN-word
// bursts on a valid/ready stream, with partial bursts on flush.
module fifo_burst_reader
  import fifo_stream_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 10,
  parameter int BURST_LEN = 16
) (
  input  logic                rclk,
  input  logic                rst_n,
  fifo_burst_reader_if.master bus,
  input  logic                flush,
  output logic                busy,
  output logic                burst_done
);
  localparam int               REM_W       = $clog2(BURST_LEN + 1);
  localparam logic [ASIZE:0]   BURST_LEN_A = (ASIZE + 1)'(BURST_LEN);
  localparam logic [REM_W-1:0] BURST_LEN_R = REM_W'(BURST_LEN);

  typedef struct packed {
    logic             last;
    logic [DSIZE-1:0] data;
  } entry_t;

  rd_state_e           state_r, state_nxt_s;
  logic [REM_W-1:0]    rem_r, rem_nxt_s;
  logic [SETTLE_W-1:0] settle_r, settle_nxt_s;
  logic                flush_pend_r, flush_pend_nxt_s;
  logic                burst_done_r;
  logic [ASIZE:0]      avail_s;
  logic                f_r_en_s, pop_s, launch_s;
  logic [1:0]          skid_cnt_s;
  entry_t              push_entry_s, head_s;
  logic                skid_valid_s;

  assign avail_s      = {1'b0, bus.f_ruse} + {{ASIZE{1'b0}}, bus.f_r_ok};
  assign pop_s        = f_r_en_s & bus.f_r_ok;
  assign push_entry_s = '{last: (rem_r == REM_W'(1)), data: bus.f_rdata};

  // Read enable depends only on registered state, never on m_ready.
  always_comb begin
    if ((state_r == BURST) && (rem_r != '0) && (skid_cnt_s < 2'd2)) begin
      f_r_en_s = 1'b1;
    end else begin
      f_r_en_s = 1'b0;
    end
  end

  // Next-state logic: launch, count down pops, then settle for stale f_ruse.
  always_comb begin
    state_nxt_s  = state_r;
    rem_nxt_s    = rem_r;
    settle_nxt_s = settle_r;
    launch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (avail_s >= BURST_LEN_A) begin
          rem_nxt_s   = BURST_LEN_R;
          state_nxt_s = BURST;
          launch_s    = 1'b1;
        end else if (flush_pend_r && (avail_s != '0)) begin
          rem_nxt_s   = REM_W'(avail_s);
          state_nxt_s = BURST;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (pop_s) begin
          rem_nxt_s = rem_r - REM_W'(1);
          if (rem_r == REM_W'(1)) begin
            state_nxt_s  = SETTLE;
            settle_nxt_s = '0;
          end else begin
            state_nxt_s = BURST;
          end
        end else begin
          state_nxt_s = BURST;
        end
      end
      SETTLE: begin
        if (settle_r == SETTLE_W'(SETTLE_CYC - 1)) begin
          state_nxt_s  = IDLE;
          settle_nxt_s = '0;
        end else begin
          settle_nxt_s = settle_r + SETTLE_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (launch_s) begin
      flush_pend_nxt_s = 1'b0;
    end else begin
      flush_pend_nxt_s = flush_pend_r | flush;
    end
  end

  // State, counters, pending flush and the registered burst-done pulse.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rem_r        <= '0;
      settle_r     <= '0;
      flush_pend_r <= 1'b0;
      burst_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      rem_r        <= rem_nxt_s;
      settle_r     <= settle_nxt_s;
      flush_pend_r <= flush_pend_nxt_s;
      burst_done_r <= skid_valid_s & bus.m_ready & head_s.last;
    end
  end

  stream_skid2 #(
    .entry_t (entry_t)
  ) u_skid (
    .clk       (rclk),
    .rst_n     (rst_n),
    .in_valid  (pop_s),
    .in_entry  (push_entry_s),
    .out_valid (skid_valid_s),
    .out_ready (bus.m_ready),
    .out_entry (head_s),
    .cnt       (skid_cnt_s)
  );

  assign bus.f_r_en  = f_r_en_s;
  assign bus.m_valid = skid_valid_s;
  assign bus.m_data  = head_s.data;
  assign bus.m_last  = head_s.last;
  assign busy        = (state_r != IDLE) | (skid_cnt_s != 2'd0);
  assign burst_done  = burst_done_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a queue-based FIFO model.
module tb_fifo_burst_reader;

  logic rclk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;
  logic burst_done;

  fifo_burst_reader_if #(.DSIZE(8), .ASIZE(4)) bus ();

  fifo_burst_reader #(
    .DSIZE     (8),
    .ASIZE     (4),
    .BURST_LEN (4)
  ) dut (
    .rclk       (rclk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic       m_ready;
    logic       f_r_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       burst_done;
  } vec_t;

  vec_t tbl [8];

  logic [7:0] fq [$];
  logic [8:0] out_q [$];
  int         pop_cyc [$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int occ = 0;
  int npop = 0;
  int occ_viol = 0;
  int busy_viol = 0;
  logic       s_f_r_en, s_m_valid, s_m_last, s_busy, s_done;
  logic [7:0] s_m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.f_r_ok  = (fq.size() != 0);
    bus.f_rdata = (fq.size() != 0) ? fq[0] : 8'h00;
    bus.f_ruse  = (fq.size() != 0) ? 4'(fq.size() - 1) : 4'd0;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'(base + 8'(i)));
    drive_fifo();
  endtask

  // One clock: sample at the falling edge, update the FIFO model after the rising edge.
  task automatic cycle();
    logic pop_l, hs_l;
    @(negedge rclk);
    pop_l     = bus.f_r_en & bus.f_r_ok;
    hs_l      = bus.m_valid & bus.m_ready;
    s_f_r_en  = bus.f_r_en;
    s_m_valid = bus.m_valid;
    s_m_data  = bus.m_data;
    s_m_last  = bus.m_last;
    s_busy    = busy;
    s_done    = burst_done;
    if (occ == 2 && bus.f_r_en) occ_viol++;
    if (bus.m_valid != (occ != 0)) occ_viol++;
    if ((pop_l || bus.m_valid) && !busy) busy_viol++;
    if (hs_l) out_q.push_back({bus.m_last, bus.m_data});
    if (pop_l) begin
      pop_cyc.push_back(cyc);
      npop++;
    end
    occ = occ + int'(pop_l) - int'(hs_l);
    @(posedge rclk);
    #1;
    cyc++;
    if (pop_l) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic clear_track();
    out_q.delete();
    pop_cyc.delete();
    occ = 0;
    npop = 0;
    occ_viol = 0;
    busy_viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b1;
    fq.delete();
    drive_fifo();
    clear_track();
    repeat (2) cycle();
    rst_n = 1'b1;
    clear_track();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check({name, "_timeout"}, 32'(out_q.size() >= n), 32'd1);
  endtask

  task automatic check_words(input string name, input logic [7:0] base, input int n, input int last_a, input int last_b);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      e = {((i == last_a) || (i == last_b)), 8'(base + 8'(i))};
      if (i < out_q.size()) check(name, 32'(out_q[i]), 32'(e));
      else check(name, 32'h1ff, 32'(e));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    // Reset held with six words waiting (f_ruse=5, f_r_ok=1).
    rst_n = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b1;
    load(8'hA0, 6);
    repeat (3) cycle();
    check("rst_outputs", {s_f_r_en, s_m_valid, s_m_data, s_m_last, s_busy, s_done}, 32'd0);
    check("rst_no_pop", 32'(npop), 32'd0);
    rst_n = 1'b1;
    clear_track();
    run_until(4, 20, "rst_first_burst");
    check_words("rst_word", 8'hA0, 4, 3, 3);

    // Full burst, cycle by cycle from the table.
    do_reset();
    load(8'h11, 4);
    for (int i = 0; i < 8; i++) begin
      logic [12:0] act, exp;
      bus.m_ready = tbl[i].m_ready;
      cycle();
      act = {s_f_r_en, s_m_valid, (s_m_valid ? s_m_data : 8'h00), (s_m_valid & s_m_last), s_busy, s_done};
      exp = {tbl[i].f_r_en, tbl[i].m_valid, tbl[i].m_data, tbl[i].m_last, tbl[i].busy, tbl[i].burst_done};
      check($sformatf("full_burst_row%0d", i), 32'(act), 32'(exp));
    end

    // Flush: three words sit until a flush, then emit as one partial burst.
    do_reset();
    load(8'h21, 3);
    repeat (20) cycle();
    check("flush_idle_no_pop", 32'(npop), 32'd0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run_until(3, 20, "flush_burst");
    check_words("flush_word", 8'h21, 3, 2, 2);
    repeat (4) cycle();
    load(8'h2F, 1);
    npop = 0;
    repeat (20) cycle();
    check("flush_pend_cleared", 32'(npop), 32'd0);

    // Backpressure: m_ready cycles 1,0,0,1 over eight words.
    do_reset();
    load(8'h01, 8);
    for (int k = 0; k < 120 && out_q.size() < 8; k++) begin
      bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      cycle();
    end
    bus.m_ready = 1'b1;
    check("bp_count", 32'(out_q.size()), 32'd8);
    check_words("bp_word", 8'h01, 8, 3, 7);
    check("bp_skid_occupancy", 32'(occ_viol), 32'd0);

    // Back-to-back bursts: three idle cycles between the bursts' pops.
    do_reset();
    load(8'h41, 8);
    run_until(8, 60, "b2b");
    check_words("b2b_word", 8'h41, 8, 3, 7);
    if (pop_cyc.size() == 8) begin
      check("b2b_burst1_rate", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
      check("b2b_gap", 32'(pop_cyc[4] - pop_cyc[3]), 32'd4);
      check("b2b_burst2_rate", 32'(pop_cyc[7] - pop_cyc[4]), 32'd3);
    end else begin
      check("b2b_pop_count", 32'(pop_cyc.size()), 32'd8);
    end
    check("b2b_busy", 32'(busy_viol), 32'd0);

    // Reset mid-burst after two beats; the remaining words form a fresh burst.
    do_reset();
    load(8'h31, 8);
    run_until(2, 20, "midrst_pre");
    rst_n = 1'b0;
    #1;
    check("midrst_drop", {bus.f_r_en, bus.m_valid, busy, bus.m_data, bus.m_last, burst_done}, 32'd0);
    clear_track();
    repeat (2) cycle();
    rst_n = 1'b1;
    clear_track();
    run_until(4, 30, "midrst_fresh");
    check_words("midrst_word", 8'h34, 4, 3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Single-clock read-side consumer for the team's asynchronous FIFO. It sits in the read clock domain, drains the FIFO's `r_en`/`r_ok`/`rdata` port, and re-emits the words as a valid/ready stream grouped into bursts of `BURST_LEN` words, with `m_last` on the final word. A burst launches when enough words are available, or on a `flush` request, which emits a partial burst.

## Interface
- `DSIZE`, default 8: data width; must match the FIFO `DSIZE`.
- `ASIZE`, default 10: FIFO address width; `f_ruse` is `ASIZE` bits.
- `BURST_LEN`, default 16: words per full burst; legal range 1 ≤ `BURST_LEN` ≤ 2^ASIZE−1.
- `rclk`  in  1  the single clock, the FIFO read clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `f_r_en`  out  1  FIFO read enable; a word transfers on a `rclk` edge when `f_r_en & f_r_ok`.
- `f_r_ok`  in  1  FIFO word valid.
- `f_rdata`  in  DSIZE  FIFO data; valid while `f_r_ok`, held while `f_r_en` is low.
- `f_ruse`  in  ASIZE  FIFO read-domain used count; excludes the word currently presented on `f_rdata`.
- `flush`  in  1  single-cycle request to emit a partial burst.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_data`  out  DSIZE  stream data.
- `m_last`  out  1  marks the final word of a burst.
- `busy`  out  1  high when state ≠ IDLE or the skid buffer is non-empty.
- `burst_done`  out  1  one-cycle pulse, registered, in the cycle after the `m_last` handshake.

## Operation
- Available words: `avail = f_ruse + f_r_ok`, computed at ASIZE+1 bits with no overflow.
- `flush_pend`:
  - Set by `flush`.
  - Cleared when any burst launches, including a launch in the same cycle as the `flush`.
  - A `flush` arriving during BURST or SETTLE stays pending until the next IDLE evaluation.
- **IDLE**:
  - If `avail ≥ BURST_LEN`: load `rem = BURST_LEN` and go to BURST.
  - Else if `flush_pend` and `avail ≠ 0`: load `rem = avail` and go to BURST.
  - Else stay in IDLE. A flush with an empty FIFO stays pending until data arrives.
- **BURST**:
  - `f_r_en = (rem ≠ 0) & (skid_cnt < 2)`. `f_r_en` is driven only from registers; there is no combinational path from `m_ready`.
  - Each pop decrements `rem` and pushes `{rem==1, f_rdata}` into the skid buffer.
  - After the pop with `rem == 1`, go to SETTLE.
  - If `f_r_ok` stays low, stall in BURST indefinitely; there is no timeout.
- **SETTLE**: 2 cycles, counted by `settle_cnt`, then go to IDLE. This absorbs the registered lag of `f_ruse` behind the FIFO read pointer, so a stale count is never used.
- **Skid buffer**: 2 entries of `{last, data}`.
  - `m_valid = skid_cnt ≠ 0`; `m_data`/`m_last` come from the head entry.
  - A push and a pop in the same cycle keep `skid_cnt` unchanged.
  - No word is ever dropped or duplicated.
- `rem` width: $clog2(BURST_LEN+1).

## Timing
- Reset (asynchronous, any time including mid-burst):
  - State = IDLE; `rem`, `settle_cnt`, `flush_pend`, `skid_cnt` = 0.
  - Outputs: `f_r_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `burst_done`=0.
  - Words already held in the skid buffer are discarded.
- Launch: the condition is seen at edge N; state is BURST from N, and `f_r_en` can be high in the cycle after N.
- Pop-to-output latency: 1 cycle. A word popped at edge K gives `m_valid` high after K.
- Throughput: 1 word/cycle while `m_ready`=1 and `f_r_ok`=1.
- Burst-to-burst gap: the last pop, then 2 SETTLE cycles, then an IDLE evaluation cycle. The first pop of the next burst follows the cycle after that evaluation.
- Backpressure: with `m_ready` low, at most 2 further pops occur, then `f_r_en` stays low.

## Structure
- A shared package `fifo_stream_pkg` holds:
  - the state encoding `IDLE`/`BURST`/`SETTLE`;
  - the `SETTLE_CYC=2` constant;
  - the skid-entry typedef `{last, data}`.
- One sub-module, `stream_skid2`: a 2-entry valid/ready buffer carrying `{last, data}`, with a registered `cnt` output.
- The top level contains the FSM, `rem`, `settle_cnt` and `flush_pend`.

## Test plan
All scenarios use DSIZE=8, ASIZE=4, BURST_LEN=4.
- **Reset**: hold `rst_n`=0 with `f_r_ok`=1 and `f_ruse`=5 → all outputs 0; after release, the first burst starts.
- **Full burst**: preload 0x11–0x14 (`avail`=4), `m_ready`=1 → `m_data` 11,12,13,14 on consecutive cycles; `m_last` only on 0x14; one `burst_done` pulse.
- **Flush**: 3 words present, no `flush` for 20 cycles → `f_r_en` stays 0. Then a `flush` pulse → 3 words out with `m_last` on the third; `flush_pend` clears.
- **Backpressure**: 8 words present, `m_ready` toggling 1,0,0,1 → output order 1..8 with no loss or duplicate; `f_r_en`=0 whenever `skid_cnt`=2; `m_last` on words 4 and 8.
- **Back-to-back**: 8 words present, `m_ready`=1 → two bursts; the gap between the last pop and the next first pop is exactly 3 idle cycles; `busy` stays high throughout.
- **Reset mid-burst**: `rst_n` low after 2 beats → `m_valid`/`f_r_en`/`busy` drop immediately; after release, a fresh burst starts from the remaining words.
